// File: rtl/imem_program_loader.sv
// imem_program_loader: assembles a host byte stream into words, writes them to imem, then releases the core
module imem_program_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  start,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst_n,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);
  typedef enum logic [2:0] {LEN, DATA, WRITE, DONE, ERR} state_t;
  localparam logic [32:0] CAP = 33'd1 << ADDR_WIDTH;
  state_t state, state_n;
  logic [1:0] byte_cnt;
  logic [31:0] len, word, len_full, word_full;
  logic [ADDR_WIDTH:0] wl_inc;
  logic xfer, last_byte, rearm;
  assign xfer = in_valid && in_ready;
  assign last_byte = xfer && byte_cnt == 2'd3;
  assign rearm = (state == DONE || state == ERR) && start;
  assign len_full = {in_data, len[23:0]};
  assign word_full = {in_data, word[23:0]};
  assign wl_inc = words_loaded + {{ADDR_WIDTH{1'b0}}, 1'b1};
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= LEN;
    else state <= state_n;
  // next-state logic
  always_comb begin
    state_n = state;
    case (state)
      LEN:     if (last_byte) state_n = ({1'b0, len_full} > CAP) ? ERR : (len_full == 32'd0 ? DONE : DATA);
      DATA:    if (last_byte) state_n = WRITE;
      WRITE:   state_n = (32'(wl_inc) == len) ? DONE : DATA;
      DONE,
      ERR:     if (start) state_n = LEN;
      default: state_n = LEN;
    endcase
  end
  // registered outputs and datapath; outputs follow the state being entered
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      in_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      core_rst_n   <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      byte_cnt     <= '0;
      len          <= '0;
      word         <= '0;
    end else begin
      in_ready   <= state_n == LEN || state_n == DATA;
      imem_we    <= state_n == WRITE;
      core_rst_n <= state_n == DONE;
      done       <= state_n == DONE;
      error      <= state_n == ERR;
      if (xfer) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (state == LEN) len[{byte_cnt, 3'b000} +: 8] <= in_data;
        else word[{byte_cnt, 3'b000} +: 8] <= in_data;
      end
      if (state == DATA && last_byte) begin
        imem_addr  <= words_loaded[ADDR_WIDTH-1:0];
        imem_wdata <= word_full;
      end
      if (state == WRITE) words_loaded <= wl_inc;
      if (rearm) begin
        words_loaded <= '0;
        byte_cnt     <= '0;
      end
    end
endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Boot-time stage directly upstream of the single-cycle RISC-V core.
- Accepts a little-endian byte stream from a host link (UART/debug bridge) over a valid/ready handshake and assembles it into 32-bit instruction words.
- Writes those words into instruction memory through its write port.
- Holds the core in reset (core reset is active-low) until the whole program is written, then releases it.

Parameters:
- ADDR_WIDTH, 10, word-address width of instruction memory; capacity = 2^ADDR_WIDTH words.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_ready  out  1  loader can accept a byte this cycle.
- start  in  1  re-arm pulse; honoured only in DONE or ERR.
- imem_we  out  1  instruction-memory write enable, one-cycle pulse per word.
- imem_addr  out  ADDR_WIDTH  word address of the write.
- imem_wdata  out  32  word to write.
- core_rst_n  out  1  core reset, active-low; 0 holds the core.
- done  out  1  program fully loaded.
- error  out  1  declared length exceeds capacity.
- words_loaded  out  ADDR_WIDTH+1  count of words written in the current load.

Behaviour:
- Reset (async, rst=1): state=LEN, byte_cnt=0, all outputs 0 (in_ready, imem_we, imem_addr, imem_wdata, core_rst_n, done, error, words_loaded). Core is held while rst is high.
- A byte transfers on a rising edge where in_valid && in_ready. in_data is ignored otherwise.
- All outputs are registered. in_ready=1 exactly in LEN and DATA.
- Byte assembly: a 2-bit byte_cnt indexes the byte lane. Byte k goes to bits [8k+7:8k], so the first byte is the LSB.
- LEN state:
  - Collects 4 bytes into a 32-bit length register N.
  - After the 4th byte: if N > 2^ADDR_WIDTH, go to ERR. Else if N==0, go to DONE. Else go to DATA.
- DATA state:
  - Collects 4 bytes into a word buffer.
  - After the 4th byte, go to WRITE.
- WRITE state (one cycle, in_ready=0):
  - imem_we=1, imem_wdata=buffer, imem_addr=words_loaded[ADDR_WIDTH-1:0].
  - On exit, words_loaded increments.
  - If the incremented count == N, go to DONE; else go back to DATA.
- Latency: imem_we is asserted in the cycle after the edge that accepted a word's 4th byte.
- DONE state:
  - done=1, core_rst_n=1 from the cycle after entering.
  - in_ready=0, so further bytes are back-pressured.
- ERR state:
  - error=1, core_rst_n=0, in_ready=0.
  - Leaving ERR requires start or rst.
- start:
  - In DONE/ERR, start=1 moves to LEN. On that edge: core_rst_n←0, done←0, error←0, words_loaded←0, byte_cnt←0.
  - In any other state, start is ignored.
- Boundaries:
  - N == 2^ADDR_WIDTH is legal. The last write uses address 2^ADDR_WIDTH−1, and words_loaded reaches 2^ADDR_WIDTH (hence the extra bit).
  - Upper length bytes above the capacity are covered by the N > 2^ADDR_WIDTH compare on all 32 bits.
  - in_valid gaps between bytes are allowed anywhere; no timeout.
  - rst asserted mid-load aborts immediately. Partially written memory is left as-is, and the core stays held.
- imem_we is never high outside WRITE; exactly one pulse per word.

Test Plan:
- Two-word load: stream 02 00 00 00, 13 05 50 00, 93 05 a0 00 → imem_we pulses at addr 0 data 0x00500513, then addr 1 data 0x00a00593. done=1, core_rst_n=1, words_loaded=2.
- Zero length: 00 00 00 00 → DONE with no imem_we pulse; core_rst_n=1 the cycle after the 4th byte's state transition.
- Overflow with ADDR_WIDTH=4: length bytes 11 00 00 00 (N=17) → error=1, core_rst_n=0, in_ready=0. Then a start pulse → error=0 and in_ready=1 next cycle.
- Full capacity with ADDR_WIDTH=4, N=16: last write at addr 15, words_loaded=16, done=1. A 17th-word byte presented afterwards is not accepted (in_ready=0).
- Throttled host: random in_valid gaps of 0–5 cycles during a 3-word load → identical writes to the gap-free run; no byte lost or duplicated.
- Reset mid-load: assert rst after 2 bytes of word 1 → outputs zero immediately. After release, a fresh stream 01 00 00 00 ef be ad de → single write at addr 0 data 0xdeadbeef.
